// File: rtl/sync_mem_pipelined.sv
// sync_mem_pipelined: parametrised single-port synchronous memory with a
// req/ready/ack handshake, byte-lane writes, a RD_LAT-deep response pipeline
// and out-of-range error reporting. A self-clearing sweep runs after reset,
// so the contents are deterministic without any preload.
//
// Parameters:
//   DATA_W  word width in bits, multiple of 8
//   ADDR_W  address width in bits
//   DEPTH   number of words, DEPTH <= 2**ADDR_W
//   RD_LAT  response latency in cycles, 1..4
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   req    request valid, accepted on an edge where req=1 and ready=1
//   we     1 = write, 0 = read
//   addr   word address
//   wdata  write data
//   be     byte enables for writes, bit i gates wdata[8i+7:8i]
//   ready  block can accept a request (low during the clearing sweep)
//   ack    one-cycle response strobe per accepted request, in order
//   rdata  read data, valid with ack on reads; 0 on write acks
//   err    qualifies ack: address was out of range
module sync_mem_pipelined #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   be,
  output logic                  ready,
  output logic                  ack,
  output logic [DATA_W-1:0]     rdata,
  output logic                  err
);

  localparam int unsigned NB_LANES = DATA_W / 8;
  localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  cnt;
  logic              accept;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] resp_data;

  logic [DATA_W-1:0] mem [DEPTH];

  // Response pipeline; stage RD_LAT-1 drives the outputs directly.
  logic [RD_LAT-1:0] pv;
  logic [RD_LAT-1:0] pe;
  logic [DATA_W-1:0] pd [RD_LAT];

  assign accept   = req & ready;
  // Full-width compare: out-of-range addresses never alias into the array.
  assign in_range = 32'(addr) < DEPTH;
  assign idx      = addr[IDX_W-1:0];
  // Write acks and out-of-range reads return zero data.
  assign resp_data = (!we && in_range) ? mem[idx] : '0;

  // Control FSM: clearing sweep, then permanent run with ready held high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_INIT;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          cnt <= cnt + IDX_W'(1);
          if (cnt == IDX_W'(DEPTH - 1)) begin
            state <= S_RUN;
            ready <= 1'b1;
          end
        end
        S_RUN: begin
          ready <= 1'b1;
        end
        default: begin
          state <= S_INIT;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: not reset, cleared by the sweep; byte-lane writes in run.
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      mem[cnt] <= '0;
    end else if (accept && we && in_range) begin
      for (int unsigned i = 0; i < NB_LANES; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Response shift register; data only moves with a valid so rdata holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      pe <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pd[i] <= '0;
      end
    end else begin
      pv[0] <= accept;
      pe[0] <= accept & ~in_range;
      if (accept) begin
        pd[0] <= resp_data;
      end
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        pe[i] <= pe[i-1];
        if (pv[i-1]) begin
          pd[i] <= pd[i-1];
        end
      end
    end
  end

  assign ack   = pv[RD_LAT-1];
  assign err   = pe[RD_LAT-1];
  assign rdata = pd[RD_LAT-1];

endmodule

// File: tb/tb_sync_mem_pipelined.sv
// Testbench for sync_mem_pipelined: a default instance (RD_LAT=1) and an
// RD_LAT=3 instance share clock and reset. A reference model (word array,
// ready countdown, and a slot table of expected responses indexed by the
// edge on which each is due) is updated on every edge and all outputs of
// both instances are compared after each edge.
module tb_sync_mem_pipelined;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req   [2];
  logic        we    [2];
  logic [7:0]  addr  [2];
  logic [15:0] wdata [2];
  logic [1:0]  be    [2];
  logic        ready [2];
  logic        ack   [2];
  logic        err   [2];
  logic [15:0] rdata [2];

  sync_mem_pipelined #(.DATA_W(16), .ADDR_W(8), .DEPTH(128), .RD_LAT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .be(be[0]), .ready(ready[0]), .ack(ack[0]),
    .rdata(rdata[0]), .err(err[0])
  );

  sync_mem_pipelined #(.DATA_W(16), .ADDR_W(8), .DEPTH(128), .RD_LAT(3)) u_b (
    .clk(clk), .rst_n(rst_n), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .be(be[1]), .ready(ready[1]), .ack(ack[1]),
    .rdata(rdata[1]), .err(err[1])
  );

  int cyc   = 0;
  int n_vec = 0;
  int n_bad = 0;

  // Reference model state per instance.
  logic [15:0] mm    [2][128];
  bit          rdy_m [2];
  int          init_m[2];
  bit          pv_m  [2][8];
  bit          pe_m  [2][8];
  logic [15:0] pd_m  [2][8];
  logic [15:0] rd_m  [2];

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s[%0d] cyc=%0d observed=%h expected=%h", tag, k, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      rdy_m[k]  = 1'b0;
      init_m[k] = 0;
      rd_m[k]   = 16'h0;
      for (int s = 0; s < 8; s++) begin
        pv_m[k][s] = 1'b0;
        pe_m[k][s] = 1'b0;
        pd_m[k][s] = 16'h0;
      end
      // Contents are lost; the sweep leaves every word at zero.
      for (int a = 0; a < 128; a++) mm[k][a] = 16'h0;
    end
  endtask

  task automatic model_edge(input int k);
    int s;
    bit oor;
    if (rst_n) begin
      if (!rdy_m[k]) begin
        init_m[k]++;
        if (init_m[k] == 128) rdy_m[k] = 1'b1;
      end else if (req[k]) begin
        s   = (cyc + lat(k) - 1) % 8;
        oor = (addr[k] >= 8'd128);
        pv_m[k][s] = 1'b1;
        pe_m[k][s] = oor;
        if (we[k]) begin
          pd_m[k][s] = 16'h0;
          if (!oor) begin
            for (int b = 0; b < 2; b++)
              if (be[k][b]) mm[k][addr[k][6:0]][8*b +: 8] = wdata[k][8*b +: 8];
          end
        end else begin
          pd_m[k][s] = oor ? 16'h0 : mm[k][addr[k][6:0]];
        end
      end
    end
  endtask

  task automatic check_all();
    int  s;
    bit  eack;
    bit  eerr;
    s = cyc % 8;
    for (int k = 0; k < 2; k++) begin
      eack = pv_m[k][s];
      eerr = eack & pe_m[k][s];
      if (eack) rd_m[k] = pd_m[k][s];
      pv_m[k][s] = 1'b0;
      chk("ack",   k, 32'(ack[k]),   32'(eack));
      chk("err",   k, 32'(err[k]),   32'(eerr));
      chk("rdata", k, 32'(rdata[k]), 32'(rd_m[k]));
      chk("ready", k, 32'(ready[k]), 32'(rdy_m[k]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) model_edge(k);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic op(input int k, input bit w, input logic [7:0] a, input logic [15:0] d, input logic [1:0] b);
    req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d; be[k] = b;
    tick();
    req[k] = 1'b0;
  endtask

  // Asynchronous reset: outputs checked immediately, then held for two edges.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    idle(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; addr[k] = 8'h0; wdata[k] = 16'h0; be[k] = 2'b00;
    end
    do_reset();

    // Sweep: requests on both instances while ready is low must be ignored.
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 8'd5;
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 8'd1; wdata[1] = 16'hDEAD; be[1] = 2'b11;
    idle(128);
    req[0] = 1'b0; req[1] = 1'b0;
    idle(3);
    op(0, 1'b0, 8'd5, 16'h0, 2'b00);

    // Back-to-back writes then reads on the latency-1 instance.
    op(0, 1'b1, 8'd20, 16'h311E, 2'b11);
    op(0, 1'b1, 8'd21, 16'h711F, 2'b11);
    op(0, 1'b1, 8'd22, 16'hB120, 2'b11);
    op(0, 1'b1, 8'd30, 16'h0005, 2'b11);
    op(0, 1'b1, 8'd31, 16'h0008, 2'b11);
    op(0, 1'b0, 8'd30, 16'h0, 2'b00);
    op(0, 1'b0, 8'd31, 16'h0, 2'b00);
    idle(1);

    // Byte-lane merge, then a no-op write with be=0.
    op(0, 1'b1, 8'd40, 16'hFFFF, 2'b11);
    op(0, 1'b1, 8'd40, 16'h12AB, 2'b01);
    op(0, 1'b0, 8'd40, 16'h0, 2'b00);
    op(0, 1'b1, 8'd40, 16'h5555, 2'b00);
    op(0, 1'b0, 8'd40, 16'h0, 2'b00);

    // Out-of-range read and write, boundary addresses, no aliasing.
    op(0, 1'b0, 8'd200, 16'h0, 2'b00);
    op(0, 1'b1, 8'd200, 16'hBEEF, 2'b11);
    op(0, 1'b0, 8'd72, 16'h0, 2'b00);
    op(0, 1'b1, 8'd127, 16'hA5A5, 2'b11);
    op(0, 1'b0, 8'd128, 16'h0, 2'b00);
    op(0, 1'b0, 8'd127, 16'h0, 2'b00);
    op(0, 1'b0, 8'd255, 16'h0, 2'b00);
    idle(2);

    // Latency-3 instance: writes then back-to-back reads, acks in order.
    for (int i = 1; i <= 4; i++) op(1, 1'b1, 8'(i), 16'(16'h1000 * i + i), 2'b11);
    for (int i = 1; i <= 4; i++) op(1, 1'b0, 8'(i), 16'h0, 2'b00);
    idle(4);
    // Read-after-write on the following edge.
    op(1, 1'b1, 8'd9, 16'hC0DE, 2'b11);
    op(1, 1'b0, 8'd9, 16'h0, 2'b00);
    idle(4);

    // Randomised traffic on both instances, biased toward a few hot addresses.
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 2; k++) begin
        req[k]   = ($urandom_range(0, 3) != 0);
        we[k]    = $urandom_range(0, 1) == 1;
        addr[k]  = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(120, 255)) : 8'($urandom_range(0, 7));
        wdata[k] = 16'($urandom);
        be[k]    = 2'($urandom_range(0, 3));
      end
      tick();
    end
    req[0] = 1'b0; req[1] = 1'b0;
    idle(4);

    // Reset with reads in flight: no stale acks, contents cleared by the sweep.
    op(0, 1'b1, 8'd20, 16'h311E, 2'b11);
    op(1, 1'b1, 8'd20, 16'h311E, 2'b11);
    op(1, 1'b0, 8'd20, 16'h0, 2'b00);
    op(1, 1'b0, 8'd20, 16'h0, 2'b00);
    do_reset();
    idle(130);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 8'd20;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 8'd20;
    tick();
    req[0] = 1'b0; req[1] = 1'b0;
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
